addr_exc_pipe: RTL and testbench
================================

ADDR_EXC_PIPE -- requirements
Module: addr_exc_pipe

Interface
REQ-001 SHALL have parameter PC_LO, default 32'h0000_3000, lowest legal fetch address (inclusive).
REQ-002 SHALL have parameter PC_HI, default 32'h0000_4FFF, highest legal fetch byte (inclusive).
REQ-003 SHALL have parameter DM_LO, default 32'h0000_0000, lowest legal data address (inclusive).
REQ-004 SHALL have parameter DM_HI, default 32'h0000_2FFF, highest legal data byte (inclusive).
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port pc_F  in  32  fetch PC; pc_valid_F  in  1  fetch slot holds an instruction.
REQ-008 SHALL have port stall_D  in  1  hold D register, bubble into E.
REQ-009 SHALL have port flush  in  1  kill D, E, M contents.
REQ-010 SHALL have port mem_addr_E  in  32  data address computed in E.
REQ-011 SHALL have ports mem_rd_E, mem_wr_E  in  1 each  load/store in E (both high: treated as store).
REQ-012 SHALL have port mem_size_E  in  2  0 byte, 1 half, 2 word, 3 treated as word.
REQ-013 SHALL have ports exc_valid_M  out  1, exc_code_M  out  5, exc_pc_M  out  32  registered M-stage exception report.

Function
REQ-014 Fetch check SHALL flag code 4 (AdEL) when pc_F[1:0]!=0, pc_F<PC_LO or pc_F+3>PC_HI; else code 0.
REQ-015 Data check SHALL flag misalignment (half: addr[0]; word: addr[1:0]) or addr<DM_LO or addr+size_bytes-1>DM_HI, using 33-bit sum so wrap past 32'hFFFF_FFFF is an error.
REQ-016 Data error code SHALL be 4 for load, 5 (AdES) for store; no check when neither mem_rd_E nor mem_wr_E.
REQ-017 D register SHALL capture {pc_valid_F, pc_F, fetch code} each edge unless stall_D.
REQ-018 E register SHALL capture D contents each edge; when stall_D, E SHALL load a bubble (valid=0).
REQ-019 M register SHALL capture E each edge; code_M = code_E if nonzero (older exception wins), else data-check code.
REQ-020 exc_valid_M SHALL equal valid_M && code_M!=0; exc_code_M SHALL be 0 whenever exc_valid_M is 0.
REQ-021 exc_pc_M SHALL carry the PC of the instruction in M.
REQ-022 Latency: fetch error at pc_F visible on exc_valid_M 3 edges later with no stalls; data error 1 edge after E.
REQ-023 flush SHALL clear valid in D, E, M on the same edge; flush with stall_D SHALL flush.
REQ-024 Invalid slots (valid=0) SHALL never raise exc_valid_M, regardless of address inputs.

Reset
REQ-025 On reset edge all stage valids, codes and PCs SHALL become 0; exc_valid_M=0, exc_code_M=0, exc_pc_M=0 next cycle.
REQ-026 reset SHALL override stall_D and flush; asserted mid-stream it SHALL discard all in-flight exceptions.

Configuration
REQ-027 With ADDR_EXC_CNT_EN defined, port exc_cnt  out  16 SHALL count edges where M loads an exception, saturate at 16'hFFFF, clear on reset.
REQ-028 Without ADDR_EXC_CNT_EN, exc_cnt port and counter logic SHALL be absent; all other behaviour identical.

Structure
REQ-029 Shared package exc_pkg SHALL hold EXC_NONE=0, EXC_ADEL=4, EXC_ADES=5 and size encodings SZ_B/SZ_H/SZ_W.
REQ-030 Sub-module addr_range_chk (addr, size, lo, hi -> err) SHALL be instantiated twice: fetch (size word) and data.

Verification
REQ-031 pc_F=32'h3000, 32'h4FFC valid, no stall -> exc_valid_M stays 0; pc_F=32'h4FFD -> code 4, exc_pc_M=32'h4FFD after 3 edges.
REQ-032 E store word at 32'h2FFE -> code 5 next edge; load half at 32'h2FFE -> no exception; load byte 32'h3000 -> code 4.
REQ-033 pc_F=32'h2FFC (fetch error) carrying a store to 32'h0001 -> exc_code_M=4 (older wins), not 5.
REQ-034 Bad pc_F with stall_D held 2 cycles -> bubbles in E/M, exception appears exactly once after release; flush concurrent with stall -> no exception.
REQ-035 mem_addr_E=32'hFFFF_FFFE word store with DM_HI=32'hFFFF_FFFF -> code 5 (wrap); reset asserted with exception in E -> exc_valid_M=0 after reset edge.
REQ-036 ADDR_EXC_CNT_EN defined: 3 faulting instructions -> exc_cnt=3; force counter at 16'hFFFF plus one fault -> stays 16'hFFFF.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared exception codes and access-size encodings for the address-exception pipeline.
package exc_pkg;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

endpackage

// File: rtl/addr_range_chk.sv
// Alignment and inclusive window check for one access of 1, 2 or 4 bytes.
module addr_range_chk
  import exc_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  output logic        err
);

  logic [32:0] last;
  logic        misaligned;

  // Last byte is formed in 33 bits so an access running past the top of memory is caught.
  always_comb begin
    last       = {1'b0, addr};
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        last       = {1'b0, addr};
        misaligned = 1'b0;
      end
      SZ_H: begin
        last       = {1'b0, addr} + 33'd1;
        misaligned = addr[0];
      end
      default: begin
        last       = {1'b0, addr} + 33'd3;
        misaligned = (addr[1:0] != 2'b00);
      end
    endcase
  end

  assign err = misaligned | (addr < lo) | (last > {1'b0, hi});

endmodule

// File: rtl/addr_exc_pipe.sv
// D/E/M address-exception tracker; define ADDR_EXC_CNT_EN to add the saturating exc_cnt output.
module addr_exc_pipe
  import exc_pkg::*;
#(
  parameter logic [31:0] PC_LO = 32'h0000_3000,
  parameter logic [31:0] PC_HI = 32'h0000_4FFF,
  parameter logic [31:0] DM_LO = 32'h0000_0000,
  parameter logic [31:0] DM_HI = 32'h0000_2FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_F,
  input  logic        pc_valid_F,
  input  logic        stall_D,
  input  logic        flush,
  input  logic [31:0] mem_addr_E,
  input  logic        mem_rd_E,
  input  logic        mem_wr_E,
  input  logic [1:0]  mem_size_E,
  output logic        exc_valid_M,
  output logic [4:0]  exc_code_M,
  output logic [31:0] exc_pc_M
`ifdef ADDR_EXC_CNT_EN
  ,
  output logic [15:0] exc_cnt
`endif
);

  logic        fetch_err;
  logic        data_err;
  logic [4:0]  fetch_code;
  logic [4:0]  data_code;
  logic [4:0]  code_m_next;

  logic        valid_d, valid_e, valid_m;
  logic [31:0] pc_d, pc_e, pc_m;
  logic [4:0]  code_d, code_e, code_m;

  addr_range_chk u_fetch_chk (
    .addr (pc_F),
    .size (SZ_W),
    .lo   (PC_LO),
    .hi   (PC_HI),
    .err  (fetch_err)
  );

  addr_range_chk u_data_chk (
    .addr (mem_addr_E),
    .size (mem_size_E),
    .lo   (DM_LO),
    .hi   (DM_HI),
    .err  (data_err)
  );

  assign fetch_code = fetch_err ? EXC_ADEL : EXC_NONE;

  // A store takes priority when both strobes are high.
  always_comb begin
    data_code = EXC_NONE;
    if (mem_wr_E && data_err)
      data_code = EXC_ADES;
    else if (!mem_wr_E && mem_rd_E && data_err)
      data_code = EXC_ADEL;
  end

  assign code_m_next = (code_e != EXC_NONE) ? code_e : data_code;

  // NOTE: reset is synchronous, so it lives inside the clocked block and overrides flush and stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_d <= 1'b0;
      pc_d    <= '0;
      code_d  <= EXC_NONE;
      valid_e <= 1'b0;
      pc_e    <= '0;
      code_e  <= EXC_NONE;
      valid_m <= 1'b0;
      pc_m    <= '0;
      code_m  <= EXC_NONE;
    end else begin
      // NOTE: non-blocking assignments let each stage read the previous stage's old value.
      if (flush) begin
        valid_d <= 1'b0;
      end else if (!stall_D) begin
        valid_d <= pc_valid_F;
        pc_d    <= pc_F;
        code_d  <= fetch_code;
      end

      valid_e <= valid_d && !stall_D && !flush;
      pc_e    <= pc_d;
      code_e  <= code_d;

      valid_m <= valid_e && !flush;
      pc_m    <= pc_e;
      code_m  <= code_m_next;
    end
  end

  assign exc_valid_M = valid_m && (code_m != EXC_NONE);
  assign exc_code_M  = exc_valid_M ? code_m : EXC_NONE;
  assign exc_pc_M    = pc_m;

`ifdef ADDR_EXC_CNT_EN
  logic m_load_exc;

  assign m_load_exc = valid_e && !flush && (code_m_next != EXC_NONE);

  always_ff @(posedge clk) begin
    if (reset)
      exc_cnt <= '0;
    else if (m_load_exc && exc_cnt != 16'hFFFF)
      exc_cnt <= exc_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_addr_exc_pipe.sv
// Self-checking bench for addr_exc_pipe: directed table, corner sequences and a randomized model run.
module tb_addr_exc_pipe;

  localparam logic [31:0] PC_LO = 32'h0000_3000;
  localparam logic [31:0] PC_HI = 32'h0000_4FFF;
  localparam logic [31:0] DM_LO = 32'h0000_0000;
  localparam logic [31:0] DM_HI = 32'h0000_2FFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_F;
  logic        pc_valid_F;
  logic        stall_D;
  logic        flush;
  logic [31:0] mem_addr_E;
  logic        mem_rd_E;
  logic        mem_wr_E;
  logic [1:0]  mem_size_E;
  logic        exc_valid_M, w_valid;
  logic [4:0]  exc_code_M, w_code;
  logic [31:0] exc_pc_M, w_pc;
`ifdef ADDR_EXC_CNT_EN
  logic [15:0] exc_cnt, w_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addr_exc_pipe #(.PC_LO(PC_LO), .PC_HI(PC_HI), .DM_LO(DM_LO), .DM_HI(DM_HI)) dut (
    .clk(clk), .reset(reset), .pc_F(pc_F), .pc_valid_F(pc_valid_F), .stall_D(stall_D),
    .flush(flush), .mem_addr_E(mem_addr_E), .mem_rd_E(mem_rd_E), .mem_wr_E(mem_wr_E),
    .mem_size_E(mem_size_E), .exc_valid_M(exc_valid_M), .exc_code_M(exc_code_M),
    .exc_pc_M(exc_pc_M)
`ifdef ADDR_EXC_CNT_EN
    , .exc_cnt(exc_cnt)
`endif
  );

  // Second instance whose data window reaches the top of the address space.
  addr_exc_pipe #(.PC_LO(PC_LO), .PC_HI(PC_HI), .DM_LO(32'h0), .DM_HI(32'hFFFF_FFFF)) dut_w (
    .clk(clk), .reset(reset), .pc_F(pc_F), .pc_valid_F(pc_valid_F), .stall_D(stall_D),
    .flush(flush), .mem_addr_E(mem_addr_E), .mem_rd_E(mem_rd_E), .mem_wr_E(mem_wr_E),
    .mem_size_E(mem_size_E), .exc_valid_M(w_valid), .exc_code_M(w_code),
    .exc_pc_M(w_pc)
`ifdef ADDR_EXC_CNT_EN
    , .exc_cnt(w_cnt)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic        pv;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        ev;
    logic [4:0]  ec;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(logic [31:0] pc, logic pv, logic [31:0] addr, logic rd, logic wr,
                              logic [1:0] size, logic ev, logic [4:0] ec, logic [31:0] epc);
    vec_t v;
    v.pc = pc; v.pv = pv; v.addr = addr; v.rd = rd; v.wr = wr; v.size = size;
    v.ev = ev; v.ec = ec; v.epc = epc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic ev, input logic [4:0] ec,
                           input logic [31:0] epc);
    check({name, ".valid"}, {31'b0, exc_valid_M}, {31'b0, ev});
    check({name, ".code"}, {27'b0, exc_code_M}, {27'b0, ec});
    if (ev) check({name, ".pc"}, exc_pc_M, epc);
  endtask

  task automatic idle_inputs();
    pc_F = '0; pc_valid_F = 1'b0; stall_D = 1'b0; flush = 1'b0;
    mem_addr_E = '0; mem_rd_E = 1'b0; mem_wr_E = 1'b0; mem_size_E = 2'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reference model: slots hold only a valid bit and a PC; codes come from address arithmetic.
  bit          md_v, me_v, mm_v;
  logic [31:0] md_pc, me_pc, mm_pc;
  logic [4:0]  mm_code;

  function automatic logic [4:0] ref_fetch(logic [31:0] pc);
    longint p = longint'({32'b0, pc});
    if ((p % 4) != 0 || p < longint'({32'b0, PC_LO}) || p + 3 > longint'({32'b0, PC_HI}))
      return 5'd4;
    return 5'd0;
  endfunction

  function automatic logic [4:0] ref_data(logic [31:0] addr, logic [1:0] size, logic rd, logic wr);
    longint a = longint'({32'b0, addr});
    longint n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    bit bad;
    if (!rd && !wr) return 5'd0;
    bad = ((a % n) != 0) || a < longint'({32'b0, DM_LO}) || a + n - 1 > longint'({32'b0, DM_HI});
    if (!bad) return 5'd0;
    return wr ? 5'd5 : 5'd4;
  endfunction

  task automatic model_edge();
    logic [4:0] fc;
    if (reset) begin
      md_v = 0; me_v = 0; mm_v = 0; mm_code = 0; mm_pc = 0;
      return;
    end
    mm_v = me_v && !flush;
    mm_pc = me_pc;
    fc = ref_fetch(me_pc);
    mm_code = (fc != 0) ? fc : ref_data(mem_addr_E, mem_size_E, mem_rd_E, mem_wr_E);
    me_v = md_v && !stall_D && !flush;
    me_pc = md_pc;
    if (flush) md_v = 0;
    else if (!stall_D) begin
      md_v = pc_valid_F;
      md_pc = pc_F;
    end
  endtask

  int seen;

  initial begin
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    check_out("reset_state", 1'b0, 5'd0, 32'h0);
    check("reset_pc", exc_pc_M, 32'h0);
    reset = 1'b0;

    // Fetch boundaries, data checks, older-exception priority, invalid slots.
    tbl[0]  = mk(32'h3000, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(32'h4FFC, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(32'h4FFD, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(32'h0,    0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(32'h0,    0, 0, 0, 0, 0, 1, 5'd4, 32'h4FFD);
    tbl[5]  = mk(32'h0,    0, 32'h2FFE, 0, 1, 2, 0, 0, 0);
    tbl[6]  = mk(32'h3000, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(32'h3004, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(32'h3008, 1, 32'h2FFE, 0, 1, 2, 1, 5'd5, 32'h3000);
    tbl[9]  = mk(32'h0,    0, 32'h2FFE, 1, 0, 1, 0, 0, 0);
    tbl[10] = mk(32'h0,    0, 32'h3000, 1, 0, 0, 1, 5'd4, 32'h3008);
    tbl[11] = mk(32'h2FFC, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(32'h0,    0, 0, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(32'h0,    0, 32'h0001, 0, 1, 2, 1, 5'd4, 32'h2FFC);
    tbl[14] = mk(32'h0,    0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      pc_F = tbl[i].pc; pc_valid_F = tbl[i].pv;
      mem_addr_E = tbl[i].addr; mem_rd_E = tbl[i].rd; mem_wr_E = tbl[i].wr;
      mem_size_E = tbl[i].size;
      tick();
      check_out($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].ec, tbl[i].epc);
    end

    // Stall held two cycles: bubbles, then a single exception after release.
    do_reset();
    seen = 0;
    pc_F = 32'h4FFD; pc_valid_F = 1'b1;
    tick();
    stall_D = 1'b1; pc_F = 32'h3000;
    tick(); check_out("stall_c1", 0, 0, 0);
    tick(); check_out("stall_c2", 0, 0, 0);
    stall_D = 1'b0;
    tick(); check_out("stall_c3", 0, 0, 0);
    pc_valid_F = 1'b0;
    tick(); check_out("stall_c4", 1, 5'd4, 32'h4FFD);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (exc_valid_M) seen++;
    end
    check("stall_once", seen, 0);

    // Flush concurrent with stall discards the faulting instruction.
    do_reset();
    pc_F = 32'h4FFD; pc_valid_F = 1'b1;
    tick();
    stall_D = 1'b1; flush = 1'b1; pc_valid_F = 1'b0;
    tick();
    stall_D = 1'b0; flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (exc_valid_M) seen++;
    end
    check("flush_stall", seen, 0);

    // Reset with a faulting instruction in E.
    do_reset();
    pc_F = 32'h5000; pc_valid_F = 1'b1;
    tick();
    pc_valid_F = 1'b0;
    tick();
    reset = 1'b1;
    tick(); check_out("reset_mid", 0, 0, 0);
    reset = 1'b0;
    tick(); check_out("reset_mid2", 0, 0, 0);

    // Word store wrapping past the top of memory on the full-range instance.
    do_reset();
    pc_F = 32'h3000; pc_valid_F = 1'b1;
    tick();
    pc_F = 32'h3004;
    tick();
    pc_valid_F = 1'b0; mem_wr_E = 1'b1; mem_size_E = 2'd2; mem_addr_E = 32'hFFFF_FFFE;
    tick();
    check("wrap.valid", {31'b0, w_valid}, 32'd1);
    check("wrap.code", {27'b0, w_code}, 32'd5);
    check("wrap.pc", w_pc, 32'h3000);
    mem_addr_E = 32'hFFFF_FFFC;
    tick();
    check("top_word.valid", {31'b0, w_valid}, 32'd0);

`ifdef ADDR_EXC_CNT_EN
    do_reset();
    check("cnt_reset", {16'b0, exc_cnt}, 32'd0);
    pc_F = 32'h5000; pc_valid_F = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    pc_valid_F = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("cnt_three", {16'b0, exc_cnt}, 32'd3);
    pc_valid_F = 1'b1;
    for (int i = 0; i < 65540; i++) tick();
    check("cnt_sat", {16'b0, exc_cnt}, 32'h0000_FFFF);
    pc_valid_F = 1'b0;
`endif

    // Randomized run against the reference model.
    do_reset();
    md_v = 0; me_v = 0; mm_v = 0; mm_code = 0; mm_pc = 0; md_pc = 0; me_pc = 0;
    for (int i = 0; i < 2000; i++) begin
      pc_F       = 32'h2FF0 + $urandom_range(0, 32'h2030);
      if ($urandom_range(0, 3) != 0) pc_F[1:0] = 2'b00;
      pc_valid_F = ($urandom_range(0, 4) != 0);
      stall_D    = ($urandom_range(0, 7) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      reset      = ($urandom_range(0, 63) == 0);
      mem_addr_E = ($urandom_range(0, 7) == 0) ? $urandom : 32'h2FE0 + $urandom_range(0, 32'h40);
      mem_rd_E   = $urandom_range(0, 1) == 1;
      mem_wr_E   = $urandom_range(0, 2) == 0;
      mem_size_E = 2'($urandom_range(0, 3));
      @(posedge clk);
      model_edge();
      #1;
      check_out($sformatf("rand%0d", i), mm_v && (mm_code != 0),
                (mm_v && mm_code != 0) ? mm_code : 5'd0, mm_pc);
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
